// File: rtl/rexta_pkg.sv
// -----------------------------------------------------------------------------
// rexta: shared types and constants for the instruction fetch slice.
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_entry_t    : one prefetched {pc, instr} pair
//   fetch_state_t    : fetch FSM states (RUN fetches, HALT issues nothing)
// -----------------------------------------------------------------------------
package rexta;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue: synchronous FIFO of fetch_entry_t used as the prefetch queue.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write push_data at the tail this cycle
//   push_data  : entry to write
//   pop        : drop the head entry this cycle (caller guarantees non-empty)
//   flush      : discard all entries; overrides push and pop
//   head       : current head entry (contents undefined while count == 0)
//   count      : number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// A push and a pop in the same cycle on a full queue is legal: the head slot
// is freed by the pop while the tail writes the slot it was already pointing to.
// -----------------------------------------------------------------------------
module fetch_queue
  import rexta::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t  entries [DEPTH];
  logic [PW-1:0] head_ptr;
  logic [PW-1:0] tail_ptr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PW'(1);
      if (pop)  head_ptr <= head_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by count alone,
  // which keeps the array a plain RAM without a reset network.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) entries[tail_ptr] <= push_data;
  end

  assign head = entries[head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit: instruction fetch stage in front of the instruction memory.
// Issues word fetches from fetch_pc, queues returned words with their address
// and hands {pc, instr} pairs to decode over valid/ready.
//   clk, rst            : clock, synchronous active-high reset
//   mem_cs, mem_addr    : fetch request and word-aligned byte address
//   mem_rdata, mem_ready: returned word, valid when mem_ready accepts request
//   redirect_valid/_pc  : control-flow change; flushes queue, reloads fetch_pc
//   out_valid/_pc/_instr: queue head towards decode (pc/instr zero when idle)
//   out_ready           : decode consumes the head this cycle
//   fault               : sticky misaligned-redirect flag
// Build option REXTA_FETCH_ALIGN_CHECK_EN: when defined, a misaligned redirect
// target raises fault and parks the FSM in HALT until an aligned redirect.
// When undefined, the low target bits are dropped and fault is tied to 0.
// -----------------------------------------------------------------------------
module fetch_unit
  import rexta::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_cs,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready,
  output logic        fault
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_L = CW'(QUEUE_DEPTH);

  fetch_state_t  state;
  fetch_state_t  state_next;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  logic          pop;
  logic          push;
  logic          misaligned;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = mem_cs && mem_ready;
  assign mem_addr  = fetch_pc;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;

`ifdef REXTA_FETCH_ALIGN_CHECK_EN
  assign misaligned = redirect_pc[1:0] != 2'b00;
  // HALT is entered only through a misaligned redirect and left only through
  // an aligned one, which is exactly the lifetime of the sticky fault.
  assign fault      = (state == FETCH_HALT);
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    mem_cs     = 1'b0;
    if (redirect_valid) state_next = misaligned ? FETCH_HALT : FETCH_RUN;
    // A pop this cycle frees a slot, so a full queue still accepts a word.
    if (!rst && state == FETCH_RUN && !redirect_valid && (count < DEPTH_L || pop))
      mem_cs = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH_RUN;
      fetch_pc <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect_valid) fetch_pc <= redirect_pc & ~32'h3;
      else if (push)      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ('{pc: fetch_pc, instr: mem_rdata}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit: directed and randomized bench for fetch_unit.
// The reference model is the architectural instruction stream: after reset or
// a redirect to T, decode must see T, T+4, T+8, ... (mod 2^32) with the word
// the ROM holds at each address, in order, with no gap or duplicate. The
// stimulus side queues that expected stream; a monitor pops and compares on
// every decode handshake.
// -----------------------------------------------------------------------------
module tb_fetch_unit;
  import rexta::*;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        mem_cs;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        fault;
  logic [31:0] junk;

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_cs         (mem_cs),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  exp_last;
  bit           exp_live = 1'b0;

  // ROM contents: an address-dependent scramble so a wrong word is visible.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Zero-wait memory; garbage on the bus whenever it is not returning data.
  always_comb mem_rdata = mem_ready ? rom(mem_addr) : junk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_topup();
    while (exp_live && exp_q.size() < 8) begin
      exp_last = exp_last + 32'd4;
      exp_q.push_back('{pc: exp_last, instr: rom(exp_last)});
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_live = 1'b1;
    exp_last = pc - 32'd4;
    sb_topup();
  endtask

  task automatic sb_halt();
    exp_q.delete();
    exp_live = 1'b0;
  endtask

  // Monitor: decode handshakes against the expected stream, idle zeros, and
  // request stability while memory stalls.
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got pc %h, expected no output", out_pc);
        end else begin
          fetch_entry_t e;
          e = exp_q.pop_front();
          check("out_pc", out_pc, e.pc);
          check("out_instr", out_instr, e.instr);
          pops++;
        end
      end
      if (!out_valid) begin
        check("idle_pc", out_pc, 32'h0);
        check("idle_instr", out_instr, 32'h0);
      end
      if (prev_wait && !redirect_valid) begin
        check_bit("hold_cs", mem_cs, 1'b1);
        check("hold_addr", mem_addr, prev_addr);
      end
      if (mem_cs) check("addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
      prev_wait = mem_cs && !mem_ready && !redirect_valid;
      prev_addr = mem_addr;
    end else begin
      prev_wait = 1'b0;
    end
  end

  // Sample point of the current cycle plus scoreboard bookkeeping for what
  // the upcoming edge does to the architectural stream.
  task automatic tick_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic tick_edge();
    if (rst) sb_restart(RPC);
    else if (redirect_valid) begin
`ifdef REXTA_FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) sb_halt();
      else sb_restart(redirect_pc);
`else
      sb_restart({redirect_pc[31:2], 2'b00});
`endif
    end
    sb_topup();
    @(posedge clk);
    #1;
    junk = $urandom;
  endtask

  task automatic cycle();
    tick_sample();
    tick_edge();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick_sample();
    check_bit("redir_cs", mem_cs, 1'b0);
    tick_edge();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] tgt;
    rst = 1'b1; mem_ready = 1'b1; out_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0; junk = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    tick_sample();
    check_bit("rst_cs", mem_cs, 1'b0);
    check_bit("rst_valid", out_valid, 1'b0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check_bit("rst_fault", fault, 1'b0);
    tick_edge();
    rst = 1'b0;

    // First fetch and first output latency, then full-rate streaming.
    tick_sample();
    check_bit("first_cs", mem_cs, 1'b1);
    check("first_addr", mem_addr, RPC);
    check_bit("first_valid", out_valid, 1'b0);
    tick_edge();
    tick_sample();
    check_bit("first_out_valid", out_valid, 1'b1);
    check("first_out_pc", out_pc, RPC);
    tick_edge();
    for (int i = 0; i < 6; i++) begin
      tick_sample();
      check_bit("stream_valid", out_valid, 1'b1);
      check("stream_pc", out_pc, RPC + 32'(4 * (i + 1)));
      tick_edge();
    end

    // Decode back-pressure fills the queue and stops fetching.
    out_ready = 1'b0;
    repeat (4) cycle();
    tick_sample();
    check_bit("full_cs", mem_cs, 1'b0);
    check_bit("full_valid", out_valid, 1'b1);
    tick_edge();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick_sample();
      check_bit("drain_valid", out_valid, 1'b1);
      tick_edge();
    end

    // Redirect while entries are queued and not consumed.
    out_ready = 1'b0;
    repeat (2) cycle();
    redirect_to(32'h0000_0100);
    out_ready = 1'b1;
    tick_sample();
    check_bit("redir_n1_valid", out_valid, 1'b0);
    check_bit("redir_n1_cs", mem_cs, 1'b1);
    check("redir_n1_addr", mem_addr, 32'h0000_0100);
    tick_edge();
    tick_sample();
    check_bit("redir_n2_valid", out_valid, 1'b1);
    check("redir_n2_pc", out_pc, 32'h0000_0100);
    tick_edge();
    repeat (3) cycle();

    // Address wrap at the top of memory.
    redirect_to(32'hFFFF_FFF8);
    cycle();
    for (int i = 0; i < 3; i++) begin
      tick_sample();
      check("wrap_pc", out_pc, 32'hFFFF_FFF8 + 32'(4 * i));
      tick_edge();
    end

    // Memory wait states: 1-0-0-1.
    mem_ready = 1'b1; cycle();
    mem_ready = 1'b0;
    tick_sample();
    held = mem_addr;
    check_bit("wait_cs", mem_cs, 1'b1);
    tick_edge();
    tick_sample();
    check("wait_addr", mem_addr, held);
    tick_edge();
    mem_ready = 1'b1;
    repeat (4) cycle();

    // Misaligned redirect.
    redirect_to(32'h0000_0102);
`ifdef REXTA_FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      tick_sample();
      check_bit("halt_fault", fault, 1'b1);
      check_bit("halt_cs", mem_cs, 1'b0);
      check_bit("halt_valid", out_valid, 1'b0);
      tick_edge();
    end
    redirect_to(32'h0000_0200);
    tick_sample();
    check_bit("resume_fault", fault, 1'b0);
    check("resume_addr", mem_addr, 32'h0000_0200);
    tick_edge();
    tick_sample();
    check("resume_pc", out_pc, 32'h0000_0200);
    tick_edge();
`else
    tick_sample();
    check_bit("noalign_fault", fault, 1'b0);
    check("noalign_addr", mem_addr, 32'h0000_0100);
    tick_edge();
    tick_sample();
    check("noalign_pc", out_pc, 32'h0000_0100);
    tick_edge();
`endif
    repeat (3) cycle();

    // Reset in mid-stream discards queue and in-flight request.
    rst = 1'b1;
    tick_sample();
    check_bit("midrst_cs", mem_cs, 1'b0);
    tick_edge();
    rst = 1'b0;
    tick_sample();
    check_bit("midrst_valid", out_valid, 1'b0);
    check("midrst_addr", mem_addr, RPC);
    tick_edge();
    tick_sample();
    check("midrst_pc", out_pc, RPC);
    tick_edge();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      else tgt = $urandom & 32'h0000_0FFC;
`ifndef REXTA_FETCH_ALIGN_CHECK_EN
      tgt = tgt | 32'($urandom_range(0, 3));
`endif
      redirect_pc = tgt;
      cycle();
    end
    redirect_valid = 1'b0;
    repeat (4) cycle();
    check_bit("progress", pops > 800, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the boot ROM / instruction memory. Generates word addresses, drives the memory's chip-select, captures returned words into a small prefetch queue, and presents `{pc, instr}` pairs to decode over a valid/ready handshake. Handles control-flow redirects with a queue flush and sustains one instruction per cycle against a zero-wait-state memory.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `QUEUE_DEPTH`, default 2: prefetch queue entries. Must be a power of two and at least 2.

- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `mem_cs`  out  1: fetch request to instruction memory.
- `mem_addr`  out  32: byte address of the requested word. Bits [1:0] are always 0.
- `mem_rdata`  in  32: word returned by memory. Valid in the same cycle as `mem_ready`.
- `mem_ready`  in  1: memory accepts the request and returns data this cycle.
- `redirect_valid`  in  1: control-flow change this cycle.
- `redirect_pc`  in  32: new fetch address.
- `out_valid`  out  1: queue head is valid.
- `out_pc`  out  32: address of the head instruction.
- `out_instr`  out  32: head instruction word.
- `out_ready`  in  1: decode consumes the head this cycle.
- `fault`  out  1: misaligned redirect target. Sticky until the next aligned redirect.

## Operation
- Registers:
  - `fetch_pc` (32 bits).
  - Queue entries `{pc, instr}` with head/tail pointers and `count`.
  - FSM state.
- FSM has two states:
  - RUN: the normal fetch state.
  - HALT: entered only with the macro below. No fetches are issued in HALT.
- FSM transitions:
  - Reset goes to RUN.
  - RUN goes to HALT on a misaligned redirect.
  - HALT goes to RUN on an aligned redirect.
- Request condition: `mem_cs = !rst && state==RUN && !redirect_valid && (count < QUEUE_DEPTH || pop)`.
  - Here `pop = out_valid && out_ready`.
- Request outputs: `mem_addr = fetch_pc`.
- Accept occurs when `mem_cs && mem_ready`. On accept:
  - Enqueue `{fetch_pc, mem_rdata}`.
  - `fetch_pc <= fetch_pc + 4`, with modulo-2^32 wrap (`0xFFFF_FFFC` goes to `0x0000_0000`).
- While `mem_ready` is low, `mem_cs` and `mem_addr` hold stable until the request is accepted or a redirect occurs.
- Pop and accept in the same cycle: `count` is unchanged, so a full queue still streams.
- Redirect has priority over everything. In a redirect cycle:
  - No accept takes place.
  - `count <= 0` and the pointers reset.
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - A pop handshake in the same cycle counts as consumed by decode. The remaining entries are discarded.
- `out_pc` and `out_instr` are driven to 0 whenever `out_valid` is 0.

## Timing
- Reset values:
  - `mem_cs=0` during reset.
  - `out_valid=0`, `out_pc=0`, `out_instr=0`, `fault=0`.
  - `fetch_pc=RESET_PC`, `count=0`, state RUN.
- First cycle after reset deasserts: `mem_cs=1` and `mem_addr=RESET_PC`.
- Latency is one cycle from accept to `out_valid`. There is no combinational bypass from `mem_rdata` to `out_*`.
- Redirect in cycle N:
  - `out_valid=0` in N+1.
  - Request to the target in N+1.
  - Target instruction valid in N+2, given zero wait states.
- Throughput: one instruction per cycle when `mem_ready` and `out_ready` are held high.
- Reset asserted mid-operation: all state returns to reset values on the next edge. Queue contents and any in-flight request are discarded.

## Configuration
- `REXTA_FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` flushes the queue, sets `fault=1` and enters HALT.
  - `fault` clears when an aligned redirect returns the FSM to RUN. The fetch to that target proceeds normally.
- `REXTA_FETCH_ALIGN_CHECK_EN` undefined:
  - `redirect_pc[1:0]` is ignored and HALT is unreachable.
  - `fault` is tied to 0.

## Structure
- Shared `rexta` package holds:
  - `RESET_PC` default constant.
  - `fetch_entry_t` packed struct `{logic [31:0] pc; logic [31:0] instr;}`.
  - `fetch_state_t` enum `{FETCH_RUN, FETCH_HALT}`.
- One sub-module, `fetch_queue`: a parameterised synchronous FIFO of `fetch_entry_t` with push/pop/flush and `count`. `fetch_unit` owns the FSM, the PC and the request logic.

## Test plan
- Reset release, `mem_ready=1`, `out_ready=1`, ROM preloaded → `out_pc` reads 0x0, 0x4, 0x8… on consecutive cycles. First `out_valid` appears 2 cycles after `rst` falls.
- `out_ready=0` for 5 cycles → queue fills with 2 entries and `mem_cs` drops. On release, the `out_pc` sequence has no gap and no duplicate.
- Redirect to 0x100 while entries for 0x8 and 0xC are queued → 0x8 and 0xC are never presented. Next `out_pc=0x100` appears 2 cycles later.
- Redirect to 0xFFFF_FFF8 → outputs are 0xFFFF_FFF8, 0xFFFF_FFFC, then 0x0000_0000.
- `mem_ready` toggling 1-0-0-1 → `mem_addr` is stable during wait cycles and no word is lost or duplicated.
- With the macro, redirect to 0x102 → `fault=1`, `mem_cs=0` and `out_valid=0`. A following redirect to 0x200 → `fault=0` and `out_pc=0x200`. Without the macro, redirect to 0x102 → `out_pc=0x100`.
